mem_latency_resp: RTL and testbench

MEM_LATENCY_RESP -- requirements
Module: mem_latency_resp

---
 rtl/mem_latency_resp_if.sv | 26 ++
 rtl/mem_latency_resp.sv | 149 ++++++++++++++
 tb/tb_mem_latency_resp.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_latency_resp_if.sv
// Request/response bus between an initiator and the fixed-latency memory responder.
// The master drives requests; the slave returns ready, completion pulses and busy.
interface mem_latency_resp_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_we;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_we, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_we, busy
    );
endinterface

// File: rtl/mem_latency_resp.sv
// Word-addressed 32-bit memory that completes each request exactly LATENCY cycles
// after acceptance, with byte-enabled writes and a one-cycle response pulse.
module mem_latency_resp #(
    parameter int LATENCY = 8,
    parameter int ADDR_W  = 10
) (
    input  logic               CLK,
    input  logic               RSTn,
    mem_latency_resp_if.slave  bus
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_n;
    logic [7:0]        cnt_r;
    logic [7:0]        cnt_n;
    logic              accept_s;
    logic              complete_s;

    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [3:0]        be_r;

    logic              ready_r;
    logic              busy_r;
    logic              resp_valid_r;
    logic              resp_we_r;
    logic [31:0]       resp_rdata_r;

    // Contents start at zero once and are deliberately never cleared by reset.
    logic [31:0]       mem_r [DEPTH] = '{default: 32'h0000_0000};

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

    // State and latency counter register.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Next-state logic; RESP is the completion cycle and may accept the next request.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        accept_s   = 1'b0;
        complete_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    cnt_n    = CNT_LOAD;
                    state_n  = WAIT;
                end else begin
                    state_n  = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 8'd0) begin
                    state_n = RESP;
                end else begin
                    cnt_n   = cnt_r - 8'd1;
                end
            end
            RESP: begin
                complete_s = 1'b1;
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    cnt_n    = CNT_LOAD;
                    state_n  = WAIT;
                end else begin
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // Capture the accepted request; inputs are ignored at every other edge.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'b0000;
        end else if (accept_s) begin
            we_r    <= bus.req_we;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
            be_r    <= bus.req_be;
        end
    end

    // Array write at completion, suppressed by reset in the same edge.
    always_ff @(posedge CLK) begin
        if (RSTn && complete_s && we_r) begin
            mem_r[addr_r] <= merge_bytes(mem_r[addr_r], wdata_r, be_r);
        end
    end

    // Registered outputs; rdata is forced to zero outside read completions.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            ready_r      <= 1'b1;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_we_r    <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            ready_r      <= (state_n != WAIT);
            busy_r       <= (state_n == WAIT);
            resp_valid_r <= complete_s;
            resp_we_r    <= complete_s & we_r;
            resp_rdata_r <= (complete_s && !we_r) ? mem_r[addr_r] : 32'h0000_0000;
        end
    end

    assign bus.req_ready  = ready_r;
    assign bus.busy       = busy_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_we    = resp_we_r;
    assign bus.resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_mem_latency_resp.sv
// Directed bench: a scoreboard of expected completions for the LATENCY=8 instance
// and a cycle-by-cycle sequence for a LATENCY=2 instance.
module tb_mem_latency_resp;
    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    mem_latency_resp_if #(.ADDR_W(10)) ifa ();
    mem_latency_resp_if #(.ADDR_W(10)) ifb ();

    mem_latency_resp #(.LATENCY(8), .ADDR_W(10)) dut_a (.CLK(CLK), .RSTn(RSTn), .bus(ifa));
    mem_latency_resp #(.LATENCY(2), .ADDR_W(10)) dut_b (.CLK(CLK), .RSTn(RSTn), .bus(ifb));

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        got;
    logic [31:0] model [1024];
    int          errors   = 0;
    int          checks   = 0;
    int          edge_cnt = 0;
    int          busy_run = 0;
    bit          skip_busy = 1'b0;
    int          t1, t2, t3;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Completion monitor for the LATENCY=8 instance.
    always @(negedge CLK) begin
        if (RSTn) begin
            if (ifa.resp_valid === 1'b1) begin
                chk32("pulse_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    chk32("resp_cycle", edge_cnt, got.due);
                    chk32("resp_we", ifa.resp_we, got.we);
                    chk32("resp_rdata", ifa.resp_rdata, got.rdata);
                end
            end else begin
                chk32("rdata_idle_zero", ifa.resp_rdata, 32'h0);
            end
            chk32("ready_vs_busy", ifa.req_ready, !ifa.busy);
        end
        if (ifa.busy === 1'b1) begin
            busy_run++;
        end else begin
            if (busy_run != 0 && !skip_busy) chk32("busy_len", busy_run, 32'd7);
            busy_run = 0;
        end
    end

    task automatic issue(input logic we, input logic [9:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input bit track, output int t_acc);
        logic [31:0] mask;
        ifa.req_valid = 1'b1;
        ifa.req_we    = we;
        ifa.req_addr  = addr;
        ifa.req_wdata = data;
        ifa.req_be    = be;
        for (int i = 0; i < 40 && ifa.req_ready !== 1'b1; i++) @(negedge CLK);
        chk32("ready_timeout", ifa.req_ready, 1'b1);
        t_acc = edge_cnt + 1;
        if (track) begin
            if (we) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                model[addr] = (model[addr] & ~mask) | (data & mask);
                sb.push_back('{we: 1'b1, rdata: 32'h0, due: t_acc + 8});
            end else begin
                sb.push_back('{we: 1'b0, rdata: model[addr], due: t_acc + 8});
            end
        end
        @(negedge CLK);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
        chk32("drain_timeout", sb.size(), 32'd0);
        @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_addr = 10'd0;
        ifa.req_wdata = 32'h0; ifa.req_be = 4'h0;
        ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_addr = 10'd0;
        ifb.req_wdata = 32'h0; ifb.req_be = 4'h0;
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        chk32("rst_ready", ifa.req_ready, 1'b1);
        chk32("rst_busy", ifa.busy, 1'b0);
        chk32("rst_valid", ifa.resp_valid, 1'b0);
        chk32("rst_rdata", ifa.resp_rdata, 32'h0);
        chk32("rst_we", ifa.resp_we, 1'b0);
        chk32("rst_b_ready", ifb.req_ready, 1'b1);
        RSTn = 1'b1;
        @(negedge CLK);

        // Full-word write, then read back.
        issue(1'b1, 10'd5, 32'hDEAD_BEEF, 4'b1111, 1'b1, t1);
        chk32("busy_after_accept", ifa.busy, 1'b1);
        ifa.req_valid = 1'b0;
        drain();
        issue(1'b0, 10'd5, 32'h0, 4'h0, 1'b1, t1);
        ifa.req_valid = 1'b0;
        drain();

        // Partial write followed by a read accepted in the RESP cycle.
        issue(1'b1, 10'd5, 32'h1122_3344, 4'b0101, 1'b1, t1);
        issue(1'b0, 10'd5, 32'h0, 4'h0, 1'b1, t2);
        ifa.req_valid = 1'b0;
        chk32("b2b_gap", t2 - t1, 32'd8);
        chk32("merge_model", model[5], 32'hDE22_BE44);
        drain();

        // Reset in the middle of a write: no pulse, array untouched.
        skip_busy = 1'b1;
        issue(1'b1, 10'd9, 32'hFFFF_FFFF, 4'b1111, 1'b0, t1);
        ifa.req_valid = 1'b0;
        for (int i = 0; i < 20 && edge_cnt < t1 + 3; i++) @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        chk32("midrst_busy", ifa.busy, 1'b0);
        chk32("midrst_ready", ifa.req_ready, 1'b1);
        repeat (12) @(negedge CLK);
        skip_busy = 1'b0;
        issue(1'b0, 10'd9, 32'h0, 4'h0, 1'b1, t1);
        ifa.req_valid = 1'b0;
        drain();

        // Three reads with req_valid held high throughout.
        issue(1'b0, 10'd5, 32'h0, 4'h0, 1'b1, t1);
        issue(1'b0, 10'd5, 32'h0, 4'h0, 1'b1, t2);
        issue(1'b0, 10'd9, 32'h0, 4'h0, 1'b1, t3);
        ifa.req_valid = 1'b0;
        chk32("held_gap1", t2 - t1, 32'd8);
        chk32("held_gap2", t3 - t2, 32'd8);
        drain();

        // A few random transactions on a small address window, including be=0000.
        for (int k = 0; k < 6; k++) begin
            issue(1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), $urandom,
                  (k == 2) ? 4'b0000 : 4'($urandom_range(0, 15)), 1'b1, t1);
        end
        for (int a = 0; a < 8; a++) issue(1'b0, 10'(a), 32'h0, 4'h0, 1'b1, t1);
        ifa.req_valid = 1'b0;
        drain();

        // LATENCY=2: write then back-to-back read, single busy cycle each.
        ifb.req_valid = 1'b1; ifb.req_we = 1'b1; ifb.req_addr = 10'd3;
        ifb.req_wdata = 32'hA5A5_0F0F; ifb.req_be = 4'b1111;
        @(negedge CLK);
        chk32("l2_busy_w", ifb.busy, 1'b1);
        chk32("l2_ready_w", ifb.req_ready, 1'b0);
        ifb.req_we = 1'b0;
        @(negedge CLK);
        chk32("l2_busy_resp", ifb.busy, 1'b0);
        chk32("l2_early_valid", ifb.resp_valid, 1'b0);
        @(negedge CLK);
        ifb.req_valid = 1'b0;
        chk32("l2_wresp_valid", ifb.resp_valid, 1'b1);
        chk32("l2_wresp_we", ifb.resp_we, 1'b1);
        chk32("l2_wresp_rdata", ifb.resp_rdata, 32'h0);
        chk32("l2_busy_r", ifb.busy, 1'b1);
        @(negedge CLK);
        chk32("l2_gap_valid", ifb.resp_valid, 1'b0);
        @(negedge CLK);
        chk32("l2_rresp_valid", ifb.resp_valid, 1'b1);
        chk32("l2_rresp_we", ifb.resp_we, 1'b0);
        chk32("l2_rresp_rdata", ifb.resp_rdata, 32'hA5A5_0F0F);
        chk32("l2_busy_done", ifb.busy, 1'b0);
        @(negedge CLK);
        chk32("l2_pulse_end", ifb.resp_valid, 1'b0);
        chk32("l2_rdata_end", ifb.resp_rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
